// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side prefetch stage: buffer sizing,
// counter types and the issue-credit helper.
package fifo_pkg;

   localparam int PREFETCH_DEPTH = 2;
   localparam int COUNT_WIDTH    = $clog2(PREFETCH_DEPTH + 1);
   localparam int FREE_WIDTH     = 3;

   typedef logic [COUNT_WIDTH-1:0] count_t;
   typedef logic [FREE_WIDTH-1:0]  free_t;

   // Buffer operation for one cycle, encoded as {push, pop}.
   typedef enum logic [1:0] {
      BUF_IDLE = 2'b00,
      BUF_POP  = 2'b01,
      BUF_PUSH = 2'b10,
      BUF_BOTH = 2'b11
   } buf_op_e;

   // Slots still available for new reads: depth minus held words minus the
   // word already on its way, plus the slot the consumer frees this cycle.
   function automatic free_t calc_free(input count_t count,
                                       input logic   inflight,
                                       input logic   pop);
      free_t depth_v;
      depth_v = free_t'(PREFETCH_DEPTH);
      return depth_v - free_t'(count) - free_t'(inflight) + free_t'(pop);
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry head/skid output buffer. The head drives the stream output; the
// skid catches a returning word while the head is still occupied.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] head,
   output count_t                count
);

   typedef logic [DATA_WIDTH-1:0] word_t;

   word_t   head_r;
   word_t   skid_r;
   count_t  count_r;
   logic    valid_r;

   word_t   head_s;
   word_t   skid_s;
   count_t  count_s;
   logic    pop_s;
   buf_op_e op_s;

   // Next-state of the buffer for every push/pop combination.
   always_comb begin
      head_s  = head_r;
      skid_s  = skid_r;
      count_s = count_r;
      pop_s   = pop && valid_r;
      op_s    = buf_op_e'({push, pop_s});
      case (op_s)
         BUF_PUSH: begin
            if (count_r == count_t'(0)) begin
               head_s  = push_data;
               count_s = count_t'(1);
            end else if (count_r == count_t'(1)) begin
               skid_s  = push_data;
               count_s = count_t'(2);
            end else begin
               count_s = count_r;
            end
         end
         BUF_POP: begin
            if (count_r == count_t'(2)) begin
               head_s  = skid_r;
               count_s = count_t'(1);
            end else begin
               count_s = count_r - count_t'(1);
            end
         end
         BUF_BOTH: begin
            // Count is unchanged; the head refills from skid if it held a
            // second word, otherwise straight from the incoming data.
            if (count_r == count_t'(2)) begin
               head_s = skid_r;
               skid_s = push_data;
            end else begin
               head_s = push_data;
            end
         end
         default: begin
            count_s = count_r;
         end
      endcase
   end

   // Buffer state registers; valid is registered alongside the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= '0;
         skid_r  <= '0;
         count_r <= count_t'(0);
         valid_r <= 1'b0;
      end else begin
         head_r  <= head_s;
         skid_r  <= skid_s;
         count_r <= count_s;
         valid_r <= (count_s != count_t'(0));
      end
   end

   assign valid = valid_r;
   assign head  = head_r;
   assign count = count_r;

endmodule

// File: rtl/fifo_read_prefetch.sv
// Read-side prefetch stage: issues RAM reads while buffer credit remains and
// turns the 1-cycle-latency read data into a valid/ready stream.
module fifo_read_prefetch
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  in_clk,
   input  logic                  in_rst_n,
   input  logic                  in_empty,
   output logic                  out_ren,
   input  logic [DATA_WIDTH-1:0] in_rdata,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  in_ready,
   output logic [1:0]            out_count
);

   typedef logic [DATA_WIDTH-1:0] word_t;

   generate
      if (ADDR_WIDTH < 1) begin : g_bad_addr_width
         $error("fifo_read_prefetch: ADDR_WIDTH must be at least 1");
      end
   endgenerate

   logic   inflight_r;
   logic   pop_s;
   logic   ren_s;
   free_t  free_s;
   count_t count_s;
   logic   valid_s;
   word_t  head_s;

   // Issue a read only when the controller has data and a slot is guaranteed
   // for the returning word; in_ready/in_empty reach out_ren combinationally.
   always_comb begin
      pop_s  = valid_s && in_ready;
      free_s = calc_free(count_s, inflight_r, pop_s);
      if (in_rst_n && !in_empty && (free_s != free_t'(0))) begin
         ren_s = 1'b1;
      end else begin
         ren_s = 1'b0;
      end
   end

   // The in-flight flag marks that in_rdata carries a word this cycle.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= ren_s;
      end
   end

   fifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid_buf (
      .clk       (in_clk),
      .rst_n     (in_rst_n),
      .push      (inflight_r),
      .push_data (in_rdata),
      .pop       (pop_s),
      .valid     (valid_s),
      .head      (head_s),
      .count     (count_s)
   );

   assign out_ren   = ren_s;
   assign out_valid = valid_s;
   assign out_data  = head_s;
   assign out_count = 2'(count_s);

endmodule

// File: tb/tb_fifo_read_prefetch.sv
// Self-checking bench: FIFO source + 1-cycle RAM model drive the DUT; a
// scoreboard queue records every word read and a monitor checks delivery.
module tb_fifo_read_prefetch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_empty;
   logic       out_ren;
   logic [7:0] in_rdata;
   logic       out_valid;
   logic [7:0] out_data;
   logic       in_ready;
   logic [1:0] out_count;

   int         checks = 0;
   int         errors = 0;
   int         delivered = 0;
   logic [7:0] src[$];
   logic [7:0] exp_q[$];
   logic [7:0] pend = 8'h00;
   bit         pend_v = 1'b0;
   bit         prev_ren = 1'b0;
   bit         last_ren = 1'b0;
   bit         last_valid = 1'b0;
   int         ready_mode = 1;

   fifo_read_prefetch #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (4)
   ) dut (
      .in_clk    (clk),
      .in_rst_n  (rst_n),
      .in_empty  (in_empty),
      .out_ren   (out_ren),
      .in_rdata  (in_rdata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .in_ready  (in_ready),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   // One clock cycle: drive inputs just after posedge, sample at negedge.
   task automatic cycle();
      in_empty = (src.size() == 0);
      case (ready_mode)
         0:       in_ready = 1'b0;
         2:       in_ready = ~in_ready;
         3:       in_ready = 1'($urandom_range(0, 1));
         default: in_ready = 1'b1;
      endcase
      if (pend_v) in_rdata = pend;
      else        in_rdata = 8'($urandom);
      pend_v = 1'b0;
      @(negedge clk);
      last_ren   = out_ren;
      last_valid = out_valid;
      chk("count_plus_inflight_le_2", int'((32'(out_count) + 32'(prev_ren)) <= 32'd2), 1);
      chk("valid_matches_count", int'(out_valid), int'(out_count != 2'd0));
      chk("ren_while_empty", int'(out_ren && in_empty), 0);
      if (out_ren && src.size() != 0) begin
         pend   = src.pop_front();
         pend_v = 1'b1;
         exp_q.push_back(pend);
      end
      prev_ren = out_ren;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   // Monitor: every transfer must match the oldest word read from the FIFO.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && in_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got %02h expected none", out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  errors++;
                  $display("FAIL stream_data: got %02h expected %02h", out_data, e);
               end
            end
            delivered++;
         end
      end
   end

   initial begin
      int n_ren;
      int base;
      rst_n    = 1'b0;
      in_empty = 1'b0;
      in_ready = 1'b1;
      in_rdata = 8'h00;

      // Reset holds everything quiet even with data available.
      repeat (3) @(negedge clk);
      chk("reset_ren", int'(out_ren), 0);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_count", int'(out_count), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      src.push_back(8'h11);
      src.push_back(8'h22);
      cycle();
      chk("ren_first_cycle_after_reset", int'(last_ren), 1);
      run(5);
      chk("reset_words_drained", exp_q.size(), 0);

      // Single word: read in cycle 0, visible for exactly cycle 2.
      ready_mode = 1;
      src.push_back(8'hA5);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk($sformatf("single_ren_c%0d", k), int'(last_ren), int'(k == 0));
         chk($sformatf("single_valid_c%0d", k), int'(last_valid), int'(k == 2));
      end

      // Streaming: eight words back to back with no gaps.
      for (int i = 1; i <= 8; i++) src.push_back(8'(i));
      for (int k = 0; k < 12; k++) begin
         cycle();
         chk($sformatf("stream_ren_c%0d", k), int'(last_ren), int'(k <= 7));
         chk($sformatf("stream_valid_c%0d", k), int'(last_valid), int'(k >= 2 && k <= 9));
      end

      // Back-pressure: only two words are prefetched, then all six drain.
      ready_mode = 0;
      for (int i = 1; i <= 6; i++) src.push_back(8'(i));
      n_ren = 0;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (last_ren) n_ren++;
      end
      chk("bp_ren_pulses", n_ren, 2);
      chk("bp_count", int'(out_count), 2);
      base = delivered;
      ready_mode = 1;
      run(12);
      chk("bp_delivered", delivered - base, 6);
      chk("bp_scoreboard_empty", exp_q.size(), 0);

      // Toggling ready across ten words.
      ready_mode = 2;
      base = delivered;
      for (int i = 0; i < 10; i++) src.push_back(8'(8'h40 + 8'(i)));
      run(40);
      chk("toggle_delivered", delivered - base, 10);
      chk("toggle_scoreboard_empty", exp_q.size(), 0);

      // Random traffic: sporadic refills, random ready.
      ready_mode = 3;
      base = delivered;
      n_ren = 0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            src.push_back(8'($urandom));
            n_ren++;
         end
         cycle();
      end
      ready_mode = 1;
      run(n_ren + 10);
      chk("random_delivered", delivered - base, n_ren);
      chk("random_scoreboard_empty", exp_q.size(), 0);

      // Asynchronous reset with a full buffer clears outputs without a clock.
      ready_mode = 0;
      for (int i = 1; i <= 5; i++) src.push_back(8'(8'h80 + 8'(i)));
      run(4);
      chk("pre_reset_count", int'(out_count), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", int'(out_valid), 0);
      chk("async_reset_count", int'(out_count), 0);
      chk("async_reset_ren", int'(out_ren), 0);
      src.delete();
      exp_q.delete();
      pend_v   = 1'b0;
      prev_ren = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_mode = 1;
      base = delivered;
      src.push_back(8'h5A);
      src.push_back(8'hC3);
      run(8);
      chk("post_reset_delivered", delivered - base, 2);
      chk("post_reset_scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
